// File: rtl/pkt_slot_fifo.sv
// Packet-slot FIFO: bytes are written by index into the current slot, a commit publishes it, and reads stream whole packets.
// Latency: first byte is valid one cycle after an accepted rinc; status flags update one cycle after a commit or final transfer.
// Backpressure: a streamed byte is held until rvalid && rready; writes and commits are refused while wfull.
module pkt_slot_fifo #(
    parameter int DEPTH      = 4,
    parameter int PTR_SZ     = 2,
    parameter int SLOT_BYTES = 11,
    parameter int IDX_SZ     = 4,
    parameter int UWIDTH     = 8,
    parameter int AF_LEVEL   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [IDX_SZ-1:0] waddr_in,
    input  logic [UWIDTH-1:0] wdata,
    input  logic              winc,
    input  logic              wabort,
    input  logic              rinc,
    input  logic              rready,
    output logic [UWIDTH-1:0] rdata,
    output logic              rvalid,
    output logic              rlast,
    output logic              rbusy,
    output logic              wfull,
    output logic              rempty,
    output logic              almost_full,
    output logic [PTR_SZ:0]   count,
    output logic              werr
);

    localparam int CW = PTR_SZ + 1;
    localparam int LW = UWIDTH + 1;
    localparam logic [IDX_SZ:0]   SB_LIM   = (IDX_SZ + 1)'(SLOT_BYTES);
    localparam logic [UWIDTH-1:0] MAX_N    = UWIDTH'(SLOT_BYTES - 4);
    localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]     AF_CNT   = CW'(AF_LEVEL);

    typedef enum logic {IDLE, STREAM} state_t;

    logic [UWIDTH-1:0] mem [DEPTH][SLOT_BYTES];
    logic [PTR_SZ-1:0] wptr;
    logic [PTR_SZ-1:0] rptr;
    state_t            state;
    logic [IDX_SZ-1:0] ridx;
    logic [LW-1:0]     len;

    logic              wr_en;
    logic              commit_req;
    logic              commit_ok;
    logic [UWIDTH-1:0] commit_size;
    logic              start;
    logic              xfer;
    logic              last_xfer;
    logic [IDX_SZ-1:0] nidx;
    logic [LW-1:0]     len_start;
    logic [CW-1:0]     count_nxt;

    // Decode write/commit/read events for this cycle; the size byte bypasses memory when written in the commit cycle
    always_comb begin
        wr_en       = wen && !wfull && ({1'b0, waddr_in} < SB_LIM);
        commit_req  = winc && !wabort;
        commit_size = (wr_en && (waddr_in == IDX_SZ'(2))) ? wdata : mem[wptr][2];
        commit_ok   = commit_req && !wfull && (commit_size <= MAX_N);
        start       = (state == IDLE) && rinc && !rempty;
        xfer        = (state == STREAM) && rvalid && rready;
        last_xfer   = xfer && rlast;
        nidx        = ridx + IDX_SZ'(1);
        len_start   = LW'(mem[rptr][2]) + LW'(4);
        count_nxt   = count + CW'(commit_ok) - CW'(last_xfer);
    end

    // Slot storage; deliberately not reset so stale bytes survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr][waddr_in] <= wdata;
        end
    end

    // Write pointer, occupancy and status flags, all registered from the next count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            count       <= '0;
            wfull       <= 1'b0;
            rempty      <= 1'b1;
            almost_full <= 1'b0;
            werr        <= 1'b0;
        end else begin
            if (commit_ok) begin
                wptr <= wptr + PTR_SZ'(1);
            end
            count       <= count_nxt;
            wfull       <= (count_nxt == FULL_CNT);
            rempty      <= (count_nxt == '0);
            almost_full <= (count_nxt >= AF_CNT);
            werr        <= commit_req && !commit_ok;
        end
    end

    // Read FSM: latch packet length on start, then step one byte per accepted transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rptr   <= '0;
            ridx   <= '0;
            len    <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            rlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= STREAM;
                        ridx   <= '0;
                        len    <= len_start;
                        rdata  <= mem[rptr][0];
                        rvalid <= 1'b1;
                        rlast  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (rlast) begin
                            state  <= IDLE;
                            rptr   <= rptr + PTR_SZ'(1);
                            rdata  <= '0;
                            rvalid <= 1'b0;
                            rlast  <= 1'b0;
                        end else begin
                            ridx  <= nidx;
                            rdata <= mem[rptr][nidx];
                            rlast <= (LW'(nidx) == (len - LW'(1)));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rbusy = (state == STREAM);

endmodule

// File: tb/tb_pkt_slot_fifo.sv
module tb_pkt_slot_fifo;
    localparam int DEPTH = 4;
    localparam int SB    = 11;
    localparam int AF    = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       wen, winc, wabort, rinc, rready;
    logic [3:0] waddr_in;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid, rlast, rbusy, wfull, rempty, almost_full, werr;
    logic [2:0] count;

    always #5 clk = ~clk;

    pkt_slot_fifo #(.DEPTH(4), .PTR_SZ(2), .SLOT_BYTES(11), .IDX_SZ(4), .UWIDTH(8), .AF_LEVEL(3)) dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr_in(waddr_in), .wdata(wdata),
        .winc(winc), .wabort(wabort), .rinc(rinc), .rready(rready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rbusy(rbusy),
        .wfull(wfull), .rempty(rempty), .almost_full(almost_full),
        .count(count), .werr(werr)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [SB-1:0][7:0] b;
        logic [SB-1:0]      k;
        logic [7:0]         len;
    } pkt_t;

    logic [SB-1:0][7:0] mm [DEPTH];
    logic [SB-1:0]      mk [DEPTH];
    int   wp;
    pkt_t q[$];
    bit   str;
    pkt_t cur;
    int   pos;
    bit   e_werr;
    logic [7:0] rx[$];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mm[i] = '0;
            mk[i] = '0;
        end
        wp = 0; str = 0; pos = 0; e_werr = 0; cur = '0;
    end

    always @(posedge clk or posedge rst) begin : mdl
        int   pre_cnt;
        bit   full, st;
        pkt_t p;
        if (rst) begin
            wp = 0; q.delete(); str = 0; pos = 0; e_werr = 0;
        end else begin
            pre_cnt = q.size() + (str ? 1 : 0);
            full    = (pre_cnt == DEPTH);
            st      = !str && rinc && (pre_cnt > 0);
            if (str && rready) begin
                rx.push_back(cur.b[pos]);
                if (pos == int'(cur.len) - 1) str = 0;
                else pos++;
            end
            if (wen && !full && waddr_in < SB) begin
                mm[wp][waddr_in] = wdata;
                mk[wp][waddr_in] = 1'b1;
            end
            e_werr = 0;
            if (winc && !wabort) begin
                if (!full && mm[wp][2] <= SB - 4) begin
                    p.b = mm[wp]; p.k = mk[wp]; p.len = mm[wp][2] + 8'd4;
                    q.push_back(p);
                    wp = (wp + 1) % DEPTH;
                end else begin
                    e_werr = 1;
                end
            end
            if (st) begin
                cur = q.pop_front();
                pos = 0;
                str = 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin : cmp
        int ec;
        if (chk_en && !rst) begin
            ec = q.size() + (str ? 1 : 0);
            chk("rvalid", rvalid, str);
            chk("rbusy", rbusy, str);
            chk("rlast", rlast, str && (pos == int'(cur.len) - 1));
            if (!str) chk("rdata_idle", rdata, 0);
            else if (cur.k[pos]) chk("rdata", rdata, cur.b[pos]);
            chk("count", count, ec);
            chk("wfull", wfull, ec == DEPTH);
            chk("rempty", rempty, ec == 0);
            chk("almost_full", almost_full, ec >= AF);
            chk("werr", werr, e_werr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drv(input bit w, input int a, input int d, input bit wi, input bit ab, input bit ri);
        @(negedge clk);
        wen = w; waddr_in = a[3:0]; wdata = d[7:0]; winc = wi; wabort = ab; rinc = ri;
    endtask

    task automatic wpkt(input int src, input int dst, input int n, input int base, input int crc,
                        input bit commit, input bit abort);
        drv(1, 0, src, 0, 0, 0);
        drv(1, 1, dst, 0, 0, 0);
        drv(1, 2, n, 0, 0, 0);
        for (int i = 0; i < n; i++) drv(1, 3 + i, base + i, 0, 0, 0);
        drv(1, 3 + n, crc, commit, abort, 0);
        drv(0, 0, 0, 0, 0, 0);
    endtask

    task automatic rpkt(input int stall_after);
        int stalls;
        int t;
        rx.delete();
        stalls = 0;
        drv(0, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0);
        chk("first_byte_valid", rvalid, 1);
        for (t = 0; t < 100; t++) begin
            if (!str) break;
            if (stall_after >= 0 && rx.size() == stall_after && stalls < 3) begin
                rready = 0; rinc = 1; stalls++;
            end else begin
                rready = 1; rinc = 0;
            end
            @(negedge clk);
        end
        rready = 1; rinc = 0;
        chk("read_done", rbusy, 0);
    endtask

    initial begin : wdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp1 [7];
        int n;
        exp1 = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd15};
        rst = 1; wen = 0; waddr_in = 0; wdata = 0; winc = 0; wabort = 0; rinc = 0; rready = 1;
        repeat (2) @(negedge clk);
        chk("rst_rempty", rempty, 1); chk("rst_count", count, 0); chk("rst_wfull", wfull, 0);
        chk("rst_rvalid", rvalid, 0); chk("rst_werr", werr, 0); chk("rst_af", almost_full, 0);
        chk("rst_rdata", rdata, 0); chk("rst_rlast", rlast, 0); chk("rst_rbusy", rbusy, 0);
        rst = 0;
        chk_en = 1;

        // 1: single packet
        wpkt(10, 160, 3, 0, 15, 1, 0);
        chk("t1_count", count, 1);
        rpkt(-1);
        chk("t1_len", rx.size(), 7);
        for (int i = 0; i < 7; i++) chk("t1_byte", rx[i], exp1[i]);
        chk("t1_empty", rempty, 1);

        // 2: fill, overflow commit, drain in order
        for (int k = 0; k < 4; k++) begin
            wpkt(k, 100 + k, 3 + k, 16 * k, 200 + k, 1, 0);
            chk("t2_count", count, k + 1);
            chk("t2_af", almost_full, (k + 1) >= 3);
        end
        chk("t2_full", wfull, 1);
        wpkt(9, 9, 1, 0, 9, 1, 0);
        chk("t2_werr", werr, 1);
        chk("t2_count_full", count, 4);
        for (int k = 0; k < 4; k++) begin
            rpkt(-1);
            chk("t2_len", rx.size(), 7 + k);
            chk("t2_src", rx[0], k);
            chk("t2_crc", rx[6 + k], 200 + k);
        end

        // 3: oversize rejected, maximum size accepted
        wpkt(1, 2, 8, 0, 0, 1, 0);
        chk("t3_werr", werr, 1);
        chk("t3_count", count, 0);
        wpkt(3, 4, 7, 64, 170, 1, 0);
        chk("t3_count2", count, 1);
        rpkt(-1);
        chk("t3_len", rx.size(), 11);
        chk("t3_crc", rx[10], 170);

        // 4: backpressure stall mid-packet with rinc during stream
        wpkt(5, 6, 5, 32, 77, 1, 0);
        rpkt(3);
        chk("t4_len", rx.size(), 9);
        for (int i = 0; i < 5; i++) chk("t4_payload", rx[3 + i], 32 + i);
        chk("t4_crc", rx[8], 77);

        // 5: final transfer coinciding with commit while full, then retry
        for (int k = 0; k < 4; k++) wpkt(20 + k, 1, 2 + k, 48, 90 + k, 1, 0);
        rx.delete();
        drv(0, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0);
        for (int t = 0; t < 40 && rlast !== 1'b1; t++) drv(0, 0, 0, 0, 0, 0);
        chk("t5_rlast", rlast, 1);
        winc = 1;
        drv(0, 0, 0, 1, 0, 0);
        chk("t5_werr", werr, 1);
        chk("t5_count3", count, 3);
        drv(0, 0, 0, 0, 0, 0);
        chk("t5_retry_count", count, 4);
        chk("t5_retry_werr", werr, 0);
        for (int k = 0; k < 4; k++) rpkt(-1);
        chk("t5_drained", count, 0);
        wpkt(7, 7, 2, 0, 7, 1, 1);
        chk("t5_abort_count", count, 0);
        chk("t5_abort_werr", werr, 0);

        // 6: wrap pointers twice, then reset mid-stream
        for (int k = 0; k < 9; k++) begin
            n = $urandom_range(0, 7);
            wpkt($urandom_range(0, 255), $urandom_range(0, 255), n, $urandom_range(0, 200), 33, 1, 0);
            rpkt(-1);
            chk("t6_len", rx.size(), n + 4);
        end
        wpkt(1, 2, 4, 8, 44, 1, 0);
        drv(0, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1;
        #1;
        chk("t6_rst_rvalid", rvalid, 0);
        chk("t6_rst_rempty", rempty, 1);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_rbusy", rbusy, 0);
        @(negedge clk);
        rst = 0;
        wpkt(11, 12, 2, 5, 66, 1, 0);
        rpkt(-1);
        chk("t6_post_len", rx.size(), 6);
        chk("t6_post_src", rx[0], 11);
        chk("t6_post_crc", rx[5], 66);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int a;
            a = $urandom_range(0, 15);
            drv($urandom_range(0, 1), a, (a == 2) ? $urandom_range(0, 9) : $urandom_range(0, 255),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
            rready = ($urandom_range(0, 3) != 0);
        end
        rready = 1;
        repeat (40) drv(0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pkt_slot_fifo.md
Name: pkt_slot_fifo

Overview:
Single-clock, parametrised packet-slot FIFO for the custom router input stage. Each slot holds one packet (src_id, dest_id, size, payload, crc). Packet bytes are written by index into the current slot, and a commit pulse publishes the slot. The read side pops a whole packet with a byte-streaming FSM under valid/ready backpressure. Adds length checking, abort, an almost-full flag and an occupancy count.

Parameters:
DEPTH, 4, number of packet slots (power of 2, >=2)
PTR_SZ, 2, log2(DEPTH)
SLOT_BYTES, 11, bytes per slot (max payload = SLOT_BYTES-4)
IDX_SZ, 4, byte-index width, 2^IDX_SZ >= SLOT_BYTES
UWIDTH, 8, byte width
AF_LEVEL, 3, count at or above which almost_full asserts (1..DEPTH)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
wen  in  1  write byte wdata at index waddr_in of current write slot
waddr_in  in  IDX_SZ  byte index within slot
wdata  in  UWIDTH  write byte
winc  in  1  commit current write slot as a packet
wabort  in  1  discard current write slot
rinc  in  1  request pop of oldest packet
rready  in  1  downstream accepts rdata this cycle
rdata  out  UWIDTH  streamed packet byte
rvalid  out  1  rdata valid
rlast  out  1  final byte (crc) of packet
rbusy  out  1  read FSM in STREAM
wfull  out  1  count == DEPTH
rempty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
count  out  PTR_SZ+1  committed, not-yet-fully-read packets
werr  out  1  one-cycle pulse: commit rejected

Behaviour:
- Reset (async, rst=1): wptr=rptr=0, count=0, FSM IDLE. Outputs: rdata=0, rvalid=0, rlast=0, rbusy=0, wfull=0, rempty=1, almost_full=0, werr=0. Memory contents are not cleared.
- Reset mid-stream aborts the packet; all staged and committed data are lost.
- Byte layout: [0]=src, [1]=dest, [2]=size N, [3..3+N-1]=payload, [3+N]=crc. Packet length L = N+4.
- Write:
  - wen && !wfull && waddr_in<SLOT_BYTES: mem[wptr][waddr_in] <= wdata at the edge.
  - Otherwise the write is ignored (no error flag).
- Commit (winc && !wabort):
  - Size is mem[wptr][2], or wdata if wen hits index 2 in the same cycle (bypass). A wen in the commit cycle is included in the packet.
  - Accepted if !wfull and N <= SLOT_BYTES-4: wptr+1 (mod DEPTH), count+1 at the edge.
  - Rejected (wfull, or N too large): werr=1 for one cycle, pointers unchanged, slot may be rewritten.
- Abort: wabort wins over winc; no pointer or count change; slot contents undefined; no werr.
- Read FSM states:
  - IDLE: rinc && !rempty → STREAM; ridx=0; latch len=mem[rptr][2]+4. rinc while empty is ignored.
  - STREAM: rbusy=1. rdata/rvalid are registered; the first byte is valid one cycle after rinc is accepted. Byte ridx is held until rvalid && rready, then ridx+1.
  - Last byte: rlast=1 on the byte at ridx==len-1. On its transfer: rptr+1 (mod DEPTH), count-1, next cycle rvalid=0 and FSM IDLE.
  - rinc during STREAM is ignored; rinc must be re-asserted after return to IDLE (min 1 idle cycle between packets).
- Simultaneous commit and final-byte transfer: count unchanged, both pointers advance. A commit accepted while wfull is impossible, so the final transfer frees the slot only from the next cycle onward.
- wfull, rempty, almost_full and count are registered and consistent with each other every cycle.
- The slot under read (rptr) is never the write slot; guaranteed by count≥1 during STREAM and wfull blocking.
- Pointer wrap: DEPTH-1 → 0, with no loss of ordering.

Test Plan:
1. DEPTH=4, SLOT_BYTES=11. Write src=10, dest=160, size=3, data 0,1,2, crc=15; winc; then rinc with rready=1 → count 1→0. Stream 10,160,3,0,1,2,15 on 7 consecutive cycles starting 1 cycle after rinc, rlast on 15, rempty=1 after.
2. Commit 4 packets (sizes 3,4,5,6), then a 5th winc → wfull=1, almost_full=1 from count 3, werr pulse on the 5th, count stays 4. Read all 4 in order with correct lengths 7,8,9,10.
3. Write size=8 (>7), winc → werr=1, count 0. Rewrite size=7 with 7 payload bytes + crc, winc → accepted, streams 11 bytes.
4. During streaming, hold rready=0 for 3 cycles mid-packet → rdata/rvalid held stable, no byte skipped or duplicated; assert rinc during STREAM → ignored.
5. With count=4, complete the final byte of a packet in the same cycle as a new winc → werr=1 (full at that edge). Retry winc next cycle → accepted, count 4. Separately: winc+wabort together → no commit.
6. Commit/read 9 packets to wrap pointers twice; assert rst mid-stream → rvalid=0, rempty=1, count=0 immediately; a subsequent packet writes and reads correctly.
